// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor: counter encodings, saturating
// counter helpers and PC index/tag extraction.
package bp_pkg;

  localparam logic [1:0] CTR_SNT = 2'd0;
  localparam logic [1:0] CTR_WNT = 2'd1;
  localparam logic [1:0] CTR_WT  = 2'd2;
  localparam logic [1:0] CTR_ST  = 2'd3;

  // Widest PC the helpers accept; callers zero-extend and truncate the result.
  localparam int unsigned PC_MAX_W = 64;

  function automatic logic [1:0] ctr_inc(input logic [1:0] c);
    return (c == CTR_ST) ? CTR_ST : c + 2'd1;
  endfunction

  function automatic logic [1:0] ctr_dec(input logic [1:0] c);
    return (c == CTR_SNT) ? CTR_SNT : c - 2'd1;
  endfunction

  // Index is pc[idx_w+1:2].
  function automatic logic [PC_MAX_W-1:0] pc_index(input logic [PC_MAX_W-1:0] pc,
                                                   input int unsigned idx_w);
    logic [PC_MAX_W-1:0] mask;
    mask = (PC_MAX_W'(1) << idx_w) - PC_MAX_W'(1);
    return (pc >> 2) & mask;
  endfunction

  // Tag is everything above the index bits.
  function automatic logic [PC_MAX_W-1:0] pc_tag(input logic [PC_MAX_W-1:0] pc,
                                                 input int unsigned idx_w);
    return pc >> (idx_w + 2);
  endfunction

endpackage

// File: rtl/bp_btb.sv
// Branch target buffer with 2-bit counters. One combinational read port for
// fetch; one synchronous update port that applies the resolve rules.
module bp_btb
  import bp_pkg::*;
#(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned PC_W    = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [PC_W-1:0] rd_pc,
  output logic            rd_hit,
  output logic [1:0]      rd_ctr,
  output logic [PC_W-1:0] rd_target,
  input  logic            wr_en,
  input  logic [PC_W-1:0] wr_pc,
  input  logic            wr_taken,
  input  logic [PC_W-1:0] wr_target
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = PC_W - IDX_W - 2;

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [PC_W-1:0]  target_q [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];

  logic [IDX_W-1:0] rd_idx, wr_idx;
  logic [TAG_W-1:0] rd_tag, wr_tag;
  logic             wr_hit;

  assign rd_idx = IDX_W'(pc_index(PC_MAX_W'(rd_pc), IDX_W));
  assign rd_tag = TAG_W'(pc_tag(PC_MAX_W'(rd_pc), IDX_W));
  assign wr_idx = IDX_W'(pc_index(PC_MAX_W'(wr_pc), IDX_W));
  assign wr_tag = TAG_W'(pc_tag(PC_MAX_W'(wr_pc), IDX_W));

  // Fetch-side lookup; sees pre-edge contents, no write bypass.
  always_comb begin
    rd_hit    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    rd_ctr    = ctr_q[rd_idx];
    rd_target = target_q[rd_idx];
    wr_hit    = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);
  end

  // Table update: train on hit, allocate on taken miss, ignore not-taken miss.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= CTR_WNT;
      end
    end else if (wr_en) begin
      if (wr_hit) begin
        ctr_q[wr_idx] <= wr_taken ? ctr_inc(ctr_q[wr_idx]) : ctr_dec(ctr_q[wr_idx]);
        if (wr_taken) target_q[wr_idx] <= wr_target;
      end else if (wr_taken) begin
        valid_q[wr_idx]  <= 1'b1;
        tag_q[wr_idx]    <= wr_tag;
        target_q[wr_idx] <= wr_target;
        ctr_q[wr_idx]    <= CTR_WT;
      end
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Dynamic branch predictor and fetch-redirect controller.
// Optional statistics counters are enabled by defining BRANCH_PRED_STATS_EN.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned PC_W    = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fetch_valid,
  input  logic [PC_W-1:0] fetch_pc,
  output logic            pred_taken,
  output logic [PC_W-1:0] pred_target,
  input  logic            res_valid,
  input  logic            res_branch,
  input  logic [PC_W-1:0] res_pc,
  input  logic            res_taken,
  input  logic [PC_W-1:0] res_target,
  input  logic            res_pred_taken,
  input  logic [PC_W-1:0] res_pred_target,
  output logic            flush,
  output logic [PC_W-1:0] redirect_pc
`ifdef BRANCH_PRED_STATS_EN
  ,
  output logic [31:0]     branch_cnt,
  output logic [31:0]     mispred_cnt
`endif
);

  logic            btb_hit;
  logic [1:0]      btb_ctr;
  logic [PC_W-1:0] btb_target;
  logic            res_upd, mispredict;
  logic            flush_d, flush_q;
  logic [PC_W-1:0] redirect_d, redirect_q;

  bp_btb #(
    .ENTRIES (ENTRIES),
    .PC_W    (PC_W)
  ) u_btb (
    .clk       (clk),
    .reset     (reset),
    .rd_pc     (fetch_pc),
    .rd_hit    (btb_hit),
    .rd_ctr    (btb_ctr),
    .rd_target (btb_target),
    .wr_en     (res_upd),
    .wr_pc     (res_pc),
    .wr_taken  (res_taken),
    .wr_target (res_target)
  );

  // Prediction and mispredict detection.
  always_comb begin
    pred_taken  = fetch_valid && btb_hit && btb_ctr[1];
    pred_target = pred_taken ? btb_target : fetch_pc + PC_W'(4);
    res_upd     = res_valid && res_branch;
    mispredict  = res_upd && ((res_taken != res_pred_taken) ||
                              (res_taken && (res_pred_target != res_target)));
    flush_d     = mispredict;
    redirect_d  = redirect_q;
    if (mispredict) redirect_d = res_taken ? res_target : res_pc + PC_W'(4);
  end

  // Registered flush/redirect; reset wins over a same-edge mispredict.
  always_ff @(posedge clk) begin
    if (reset) begin
      flush_q    <= 1'b0;
      redirect_q <= '0;
    end else begin
      flush_q    <= flush_d;
      redirect_q <= redirect_d;
    end
  end

  assign flush       = flush_q;
  assign redirect_pc = redirect_q;

`ifdef BRANCH_PRED_STATS_EN
  logic [31:0] branch_cnt_q, mispred_cnt_q;

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      if (res_upd && (branch_cnt_q != '1))     branch_cnt_q  <= branch_cnt_q + 32'd1;
      if (mispredict && (mispred_cnt_q != '1)) mispred_cnt_q <= mispred_cnt_q + 32'd1;
    end
  end

  assign branch_cnt  = branch_cnt_q;
  assign mispred_cnt = mispred_cnt_q;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: stimulus pushes expectations from a
// behavioural model; a negedge monitor pops and compares.
module tb_branch_predictor;

  localparam int unsigned ENTRIES = 16;
  localparam int unsigned PC_W    = 32;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            fetch_valid = 1'b0;
  logic [31:0]     fetch_pc = '0;
  logic            pred_taken;
  logic [31:0]     pred_target;
  logic            res_valid = 1'b0;
  logic            res_branch = 1'b0;
  logic [31:0]     res_pc = '0;
  logic            res_taken = 1'b0;
  logic [31:0]     res_target = '0;
  logic            res_pred_taken = 1'b0;
  logic [31:0]     res_pred_target = '0;
  logic            flush;
  logic [31:0]     redirect_pc;
`ifdef BRANCH_PRED_STATS_EN
  logic [31:0]     branch_cnt, mispred_cnt;
`endif

  branch_predictor #(
    .ENTRIES (ENTRIES),
    .PC_W    (PC_W)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .fetch_valid     (fetch_valid),
    .fetch_pc        (fetch_pc),
    .pred_taken      (pred_taken),
    .pred_target     (pred_target),
    .res_valid       (res_valid),
    .res_branch      (res_branch),
    .res_pc          (res_pc),
    .res_taken       (res_taken),
    .res_target      (res_target),
    .res_pred_taken  (res_pred_taken),
    .res_pred_target (res_pred_target),
    .flush           (flush),
    .redirect_pc     (redirect_pc)
`ifdef BRANCH_PRED_STATS_EN
    ,
    .branch_cnt      (branch_cnt),
    .mispred_cnt     (mispred_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Behavioural model: one record per entry, counters as plain integers.
  typedef struct {
    bit          valid;
    int unsigned tag;
    logic [31:0] target;
    int          ctr;
  } ent_t;
  ent_t model[ENTRIES];

  typedef struct { int cyc; logic [31:0] pc; } fl_t;
  typedef struct { bit taken; logic [31:0] tgt; } pr_t;
  fl_t fq[$];
  pr_t pq[$];

  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b0;
  int m_branches = 0;
  int m_mispreds = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic int unsigned m_idx(input logic [31:0] pc);
    return (pc / 4) % ENTRIES;
  endfunction

  function automatic int unsigned m_tag(input logic [31:0] pc);
    return pc / (4 * ENTRIES);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return model[m_idx(pc)].valid && model[m_idx(pc)].tag == m_tag(pc);
  endfunction

  task automatic model_predict(input logic [31:0] pc, output bit t, output logic [31:0] tgt);
    t   = m_hit(pc) && model[m_idx(pc)].ctr >= 2;
    tgt = t ? model[m_idx(pc)].target : pc + 32'd4;
  endtask

  task automatic model_reset();
    for (int i = 0; i < int'(ENTRIES); i++) begin
      model[i].valid = 1'b0;
      model[i].ctr   = 1;
    end
    m_branches = 0;
    m_mispreds = 0;
  endtask

  // One clock cycle of stimulus; expectations are pushed before the model advances.
  task automatic step(input bit fv, input logic [31:0] fpc, input bit rv, input bit rb,
                      input logic [31:0] rpc, input bit rt, input logic [31:0] rtgt,
                      input bit rpt, input logic [31:0] rptgt, input bit rst);
    bit          pt;
    logic [31:0] ptg;
    int unsigned i;
    @(posedge clk);
    #1;
    fetch_valid = fv; fetch_pc = fpc;
    res_valid = rv; res_branch = rb; res_pc = rpc; res_taken = rt; res_target = rtgt;
    res_pred_taken = rpt; res_pred_target = rptgt; reset = rst;
    if (fv) begin
      model_predict(fpc, pt, ptg);
      pq.push_back('{taken: pt, tgt: ptg});
    end
    if (rst) begin
      model_reset();
    end else if (rv && rb) begin
      m_branches++;
      if (rt != rpt || (rt && rptgt != rtgt)) begin
        m_mispreds++;
        fq.push_back('{cyc: cyc + 1, pc: rt ? rtgt : rpc + 32'd4});
      end
      i = m_idx(rpc);
      if (m_hit(rpc)) begin
        if (rt) begin
          model[i].ctr    = (model[i].ctr == 3) ? 3 : model[i].ctr + 1;
          model[i].target = rtgt;
        end else begin
          model[i].ctr = (model[i].ctr == 0) ? 0 : model[i].ctr - 1;
        end
      end else if (rt) begin
        model[i].valid  = 1'b1;
        model[i].tag    = m_tag(rpc);
        model[i].target = rtgt;
        model[i].ctr    = 2;
      end
    end
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic fetch(input logic [31:0] pc);
    step(1, pc, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic resolve(input logic [31:0] pc, input bit t, input logic [31:0] tgt,
                         input bit pt, input logic [31:0] ptg);
    step(0, 0, 1, 1, pc, t, tgt, pt, ptg, 0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 7)
      0: return 32'h100;
      1: return 32'h140;
      2: return 32'h200;
      3: return 32'h204;
      4: return 32'hFFFF_FFFC;
      default: return $urandom & 32'h0000_0FFC;
    endcase
  endfunction

  // Monitor: compare predictions when fetch is valid and flush every cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (fetch_valid) begin
        if (pq.size() == 0) begin
          chk("pred_queue_underflow", 32'd1, 32'd0);
        end else begin
          pr_t p;
          p = pq.pop_front();
          chk("pred_taken", {31'd0, pred_taken}, {31'd0, p.taken});
          chk("pred_target", pred_target, p.tgt);
        end
      end
      if (fq.size() > 0 && fq[0].cyc == cyc) begin
        fl_t f;
        f = fq.pop_front();
        chk("flush", {31'd0, flush}, 32'd1);
        chk("redirect_pc", redirect_pc, f.pc);
      end else begin
        chk("flush_idle", {31'd0, flush}, 32'd0);
      end
    end
  end

  initial begin
    bit          rv, rb, rt, pt, fv, rst;
    logic [31:0] fpc, rpc, rtgt, ptg;

    model_reset();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    mon_en = 1'b1;
    @(negedge clk);
    chk("reset_redirect_pc", redirect_pc, 32'd0);

    fetch(32'h100);                                  // cold: not taken, 0x104
    resolve(32'h100, 1, 32'h80, 0, 32'h104);         // allocate, flush to 0x80
    fetch(32'h100);                                  // now 1 / 0x80
    for (int k = 0; k < 4; k++) resolve(32'h100, 1, 32'h80, 1, 32'h80);
    resolve(32'h100, 0, 32'h80, 1, 32'h80);          // ctr 3 -> 2, flush 0x104
    fetch(32'h100);
    resolve(32'h100, 0, 32'h80, 1, 32'h80);          // ctr 2 -> 1
    fetch(32'h100);
    resolve(32'h100, 1, 32'h90, 1, 32'h80);          // wrong target, flush 0x90
    fetch(32'h100);
    resolve(32'h200, 0, 32'h300, 1, 32'h300);        // flush 0x204
    step(0, 0, 1, 1, 32'h200, 0, 32'h300, 1, 32'h300, 1);  // reset beats mispredict
    idle();
    fetch(32'h100);
    resolve(32'h100, 1, 32'h80, 0, 32'h104);
    fetch(32'h140);                                  // alias: same index, other tag
    fetch(32'h100);
    step(0, 0, 1, 0, 32'h100, 1, 32'h500, 0, 32'h0, 0);     // non-branch ignored
    fetch(32'h100);
    resolve(32'h300, 1, 32'h10, 0, 32'h304);         // back-to-back mispredicts
    resolve(32'h304, 0, 32'h20, 1, 32'h20);
    fetch(32'hFFFF_FFFC);                            // sequential target wraps to 0
    resolve(32'hFFFF_FFFC, 0, 32'h40, 1, 32'h40);    // redirect wraps to 0
    // Same-cycle fetch and update: fetch sees pre-edge table.
    step(1, 32'h400, 1, 1, 32'h400, 1, 32'h44, 0, 32'h404, 0);
    fetch(32'h400);

    for (int n = 0; n < 600; n++) begin
      fv  = $urandom % 2;
      fpc = pick();
      rv  = ($urandom % 4) != 0;
      rb  = ($urandom % 4) != 0;
      rpc = pick();
      rt  = $urandom % 2;
      rtgt = ($urandom % 2) ? pick() : rpc + 32'd8;
      if ($urandom % 2) begin
        model_predict(rpc, pt, ptg);
      end else begin
        pt  = $urandom % 2;
        ptg = ($urandom % 2) ? rtgt : pick();
      end
      rst = ($urandom % 100) == 0;
      step(fv, fpc, rv, rb, rpc, rt, rtgt, pt, ptg, rst);
    end

    idle();
    idle();
    idle();
    @(negedge clk);
    chk("flush_queue_drained", fq.size(), 32'd0);
    chk("pred_queue_drained", pq.size(), 32'd0);
`ifdef BRANCH_PRED_STATS_EN
    chk("branch_cnt", branch_cnt, m_branches);
    chk("mispred_cnt", mispred_cnt, m_mispreds);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Dynamic branch predictor and fetch-redirect controller for the RV32 core. It sits beside `branch_unit`. At fetch it predicts whether a conditional branch is taken, and to where, using a branch target buffer (BTB) and 2-bit saturating counters. At resolve it takes `PC_Src` and the computed target, updates its tables and issues a registered flush/redirect on a misprediction.

## Interface
Parameters:
- `ENTRIES`, 16: number of BTB/counter entries; power of two, at least 2; `IDX_W = $clog2(ENTRIES)`.
- `PC_W`, 32: width of PCs and targets.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `fetch_valid`, in, 1: a fetch PC is presented this cycle.
- `fetch_pc`, in, `PC_W`: fetch address, word-aligned.
- `pred_taken`, out, 1: prediction for `fetch_pc`, combinational.
- `pred_target`, out, `PC_W`: predicted target; equals `fetch_pc+4` when `pred_taken=0`.
- `res_valid`, in, 1: a resolved instruction is presented.
- `res_branch`, in, 1: the resolved instruction is a conditional branch (`Branch`).
- `res_pc`, in, `PC_W`: PC of the resolved instruction.
- `res_taken`, in, 1: actual outcome (`PC_Src` of `branch_unit`).
- `res_target`, in, `PC_W`: computed branch target.
- `res_pred_taken`, in, 1: prediction carried with this instruction.
- `res_pred_target`, in, `PC_W`: predicted target carried with this instruction.
- `flush`, out, 1: squash younger instructions, registered.
- `redirect_pc`, out, `PC_W`: correct next PC; valid while `flush=1`.

## Operation
- Index is `pc[IDX_W+1:2]`; tag is `pc[PC_W-1:IDX_W+2]`.
- Each entry holds `valid`, `tag`, `target` and a 2-bit counter `ctr`.
- Lookup:
  - hit = `valid[idx] && tag[idx]==fetch_pc tag`.
  - `pred_taken = fetch_valid && hit && ctr[idx][1]`.
  - `pred_target = pred_taken ? target[idx] : fetch_pc+4`; the addition wraps modulo 2^`PC_W`.
- Update happens only when `res_valid && res_branch`:
  - counter: taken increments and saturates at 3; not-taken decrements and saturates at 0;
  - taken and entry misses: allocate by setting `valid`, `tag` and `target`, with `ctr` set to 2'b10 (weak taken);
  - taken and entry hits: rewrite `target` and update the counter;
  - not-taken and entry misses: no table change.
- Mispredict = `res_valid && res_branch && (res_taken != res_pred_taken || (res_taken && res_pred_target != res_target))`.
- On a mispredict, at the next edge: `flush` is set to 1 and `redirect_pc` is set to `res_taken ? res_target : res_pc+4`.
- Non-branch resolves (`res_branch=0`) are ignored entirely.

## Timing
- Reset values: all `valid`=0, all `ctr`=2'b01, `flush`=0, `redirect_pc`=0. `pred_taken` is 0 while tables are invalid.
- Prediction latency is 0 cycles (combinational read). Redirect latency is 1 cycle: `flush` is high for exactly one cycle per mispredict.
- Table writes take effect at the edge. A fetch to the same index in the same cycle sees the old contents; there is no bypass.
- Back-to-back mispredicts produce `flush` on consecutive cycles, each with its own `redirect_pc`.
- `reset` asserted mid-operation clears a pending `flush` in the same edge; outputs return to reset values the next cycle.
- There is no handshake or backpressure. Resolves are accepted every cycle.

## Configuration
- `BRANCH_PRED_STATS_EN`:
  - Defined: adds outputs `branch_cnt` and `mispred_cnt`, each 32-bit. They increment on every qualifying resolve and on every mispredict respectively, saturate at all-ones, and reset to 0.
  - Undefined: the ports and counters are absent.
  - Prediction behaviour is identical either way.

## Structure
- Shared package `bp_pkg`:
  - counter encodings `CTR_SNT/WNT/WT/ST` (0..3);
  - saturating increment/decrement functions;
  - index and tag extraction functions parameterised on `IDX_W`.
- One sub-module, `bp_btb`: holds the valid/tag/target/ctr arrays, with a combinational read port and a synchronous write port.
- Mispredict detection, the flush register and the stats counters live in the top module.

## Test plan
- Reset, then fetch 0x100 → `pred_taken=0`, `pred_target=0x104`; `flush` stays 0.
- Resolve a branch at 0x100, taken to 0x80, with `res_pred_taken=0` → next cycle `flush=1` and `redirect_pc=0x80`; a following fetch of 0x100 gives `pred_taken=1`, `pred_target=0x80`.
- Resolve 0x100 taken four more times, then not-taken once → `ctr` is 3 then 2, so `pred_taken` stays 1; a second not-taken gives `pred_taken=0`.
- Resolve with prediction taken/0x80 but actual taken/0x90 → `flush=1`, `redirect_pc=0x90`.
- Resolve not-taken while predicted taken at 0x200 → `flush=1`, `redirect_pc=0x204`. Assert `reset` with a flush pending → `flush=0` next cycle and all predictions are 0.
- With `ENTRIES=16`, allocate a taken branch at 0x100, then fetch 0x140 (same index, different tag) → `pred_taken=0`. With `BRANCH_PRED_STATS_EN` defined, the counts match the number of resolves and mispredicts applied.
